// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_scheduler
//  Description : Call scheduler and motion sequencer for a single car.
//                It latches floor calls and serves them in SCAN order, moving
//                one floor every MOVE_CYCLES and opening the door for
//                DOOR_CYCLES at each served floor.
//                Optional macro ELEV_ESTOP_EN adds the estop freeze input.
//  Revision    : 1.0  initial release
// ============================================================================
module elevator_scheduler #(
    parameter int NUM_FLOORS  = 4,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 8,
    localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ELEV_ESTOP_EN
    input  logic                  estop,
`endif
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    cf,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open
);

    // Timer widths never collapse to zero bits when a cycle count is 1.
    localparam int MT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    localparam logic [MT_W-1:0]    C_MOVE_LAST = MT_W'(MOVE_CYCLES - 1);
    localparam logic [DT_W-1:0]    C_DOOR_LAST = DT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] C_TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] C_ONE_FLOOR = FLOOR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FLOOR_W-1:0]    w_cf_nxt;
    logic [MT_W-1:0]       r_move_tmr;
    logic [MT_W-1:0]       w_move_tmr_nxt;
    logic [DT_W-1:0]       r_door_tmr;
    logic [DT_W-1:0]       w_door_tmr_nxt;
    logic [NUM_FLOORS-1:0] w_pending_nxt;
    logic                  w_dir_up_nxt;
    logic                  w_estop;
    logic                  w_above;
    logic                  w_below;

`ifdef ELEV_ESTOP_EN
    assign w_estop = estop;
`else
    assign w_estop = 1'b0;
`endif

    // Any latched call strictly above floor f.
    function automatic logic calls_above(input logic [NUM_FLOORS-1:0] p,
                                         input logic [FLOOR_W-1:0]    f);
        logic any;
        any = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) any = any | p[i];
        end
        return any;
    endfunction

    // Any latched call strictly below floor f.
    function automatic logic calls_below(input logic [NUM_FLOORS-1:0] p,
                                         input logic [FLOOR_W-1:0]    f);
        logic any;
        any = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) any = any | p[i];
        end
        return any;
    endfunction

    assign w_above = calls_above(pending, cf);
    assign w_below = calls_below(pending, cf);

    // Next-state, floor, timer and call-latch decisions from registered state.
    always_comb begin
        w_state_nxt    = r_state;
        w_cf_nxt       = cf;
        w_move_tmr_nxt = r_move_tmr;
        w_door_tmr_nxt = r_door_tmr;
        w_dir_up_nxt   = dir_up;
        w_pending_nxt  = pending | req;

        if (!w_estop) begin
            case (r_state)
                S_IDLE: begin
                    if (pending[cf]) begin
                        w_state_nxt = S_DOOR;
                    end else if (w_above && w_below) begin
                        w_state_nxt = dir_up ? S_MOVE_UP : S_MOVE_DOWN;
                    end else if (w_above) begin
                        w_state_nxt  = S_MOVE_UP;
                        w_dir_up_nxt = 1'b1;
                    end else if (w_below) begin
                        w_state_nxt  = S_MOVE_DOWN;
                        w_dir_up_nxt = 1'b0;
                    end
                end
                S_MOVE_UP: begin
                    if (r_move_tmr == C_MOVE_LAST) begin
                        w_move_tmr_nxt = '0;
                        if (cf != C_TOP_FLOOR) begin
                            w_cf_nxt = cf + C_ONE_FLOOR;
                            if (pending[w_cf_nxt])
                                w_state_nxt = S_DOOR;
                            else if (!calls_above(pending, w_cf_nxt))
                                w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_move_tmr_nxt = r_move_tmr + MT_W'(1);
                    end
                end
                S_MOVE_DOWN: begin
                    if (r_move_tmr == C_MOVE_LAST) begin
                        w_move_tmr_nxt = '0;
                        if (cf != '0) begin
                            w_cf_nxt = cf - C_ONE_FLOOR;
                            if (pending[w_cf_nxt])
                                w_state_nxt = S_DOOR;
                            else if (!calls_below(pending, w_cf_nxt))
                                w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_move_tmr_nxt = r_move_tmr + MT_W'(1);
                    end
                end
                default: begin
                    // A fresh call to this floor keeps the door open longer.
                    if (req[cf]) begin
                        w_door_tmr_nxt = '0;
                    end else if (r_door_tmr == C_DOOR_LAST) begin
                        w_door_tmr_nxt = '0;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_door_tmr_nxt = r_door_tmr + DT_W'(1);
                    end
                end
            endcase
        end

        // The served floor's call is dropped on door entry and never relatched
        // while the door is open there.
        if (r_state == S_DOOR)
            w_pending_nxt[cf] = 1'b0;
        if ((w_state_nxt == S_DOOR) && (r_state != S_DOOR))
            w_pending_nxt[w_cf_nxt] = 1'b0;
    end

    // State, position, calls and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            cf         <= '0;
            pending    <= '0;
            dir_up     <= 1'b1;
            moving     <= 1'b0;
            door_open  <= 1'b0;
            r_move_tmr <= '0;
            r_door_tmr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            cf         <= w_cf_nxt;
            pending    <= w_pending_nxt;
            dir_up     <= w_dir_up_nxt;
            moving     <= !w_estop && ((w_state_nxt == S_MOVE_UP) ||
                                       (w_state_nxt == S_MOVE_DOWN));
            door_open  <= (w_state_nxt == S_DOOR);
            r_move_tmr <= w_move_tmr_nxt;
            r_door_tmr <= w_door_tmr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_scheduler
//  Description : Directed bench for elevator_scheduler (4 floors, 4-cycle
//                moves, 8-cycle door).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_elevator_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] cf;
    logic [3:0] pending;
    logic       dir_up;
    logic       moving;
    logic       door_open;
`ifdef ELEV_ESTOP_EN
    logic       estop;
`endif

    int checks;
    int errors;

    elevator_scheduler #(
        .NUM_FLOORS (4),
        .MOVE_CYCLES(4),
        .DOOR_CYCLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef ELEV_ESTOP_EN
        .estop    (estop),
`endif
        .req      (req),
        .cf       (cf),
        .pending  (pending),
        .dir_up   (dir_up),
        .moving   (moving),
        .door_open(door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] cf;
        logic [3:0] pend;
        logic       mv;
        logic       door;
        logic       dir;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        vec_t vecs[25];
        int   stops[3];
        int   nstops;
        int   d;
        int   first_door;
        bit   inj;
        bit   prev_door;
        bit   pend_bad;

        checks = 0;
        errors = 0;
        req    = '0;
        rst    = 1'b1;
`ifdef ELEV_ESTOP_EN
        estop  = 1'b0;
`endif

        // Call at the current floor, then a multi-hot call above.
        vecs[0] = '{4'b0001, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
        for (int i = 1; i <= 8; i++) vecs[i] = '{4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{4'b0110, 2'd0, 4'b0110, 1'b0, 1'b0, 1'b1};
        for (int i = 11; i <= 14; i++) vecs[i] = '{4'b0000, 2'd0, 4'b0110, 1'b1, 1'b0, 1'b1};
        for (int i = 15; i <= 22; i++) vecs[i] = '{4'b0000, 2'd1, 4'b0100, 1'b0, 1'b1, 1'b1};
        vecs[23] = '{4'b0000, 2'd1, 4'b0100, 1'b0, 1'b0, 1'b1};
        vecs[24] = '{4'b0000, 2'd1, 4'b0100, 1'b1, 1'b0, 1'b1};

        do_reset();
        chk("reset_cf", int'(cf), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_dir_up", int'(dir_up), 1);

        for (int i = 0; i < 25; i++) begin
            req = vecs[i].req;
            step();
            req = '0;
            chk($sformatf("vec%0d_cf", i), int'(cf), int'(vecs[i].cf));
            chk($sformatf("vec%0d_pending", i), int'(pending), int'(vecs[i].pend));
            chk($sformatf("vec%0d_moving", i), int'(moving), int'(vecs[i].mv));
            chk($sformatf("vec%0d_door", i), int'(door_open), int'(vecs[i].door));
            chk($sformatf("vec%0d_dir", i), int'(dir_up), int'(vecs[i].dir));
        end

        // Asynchronous reset while moving, observed before any clock edge.
        rst = 1'b1;
        #2;
        chk("async_rst_cf", int'(cf), 0);
        chk("async_rst_pending", int'(pending), 0);
        chk("async_rst_moving", int'(moving), 0);
        chk("async_rst_door", int'(door_open), 0);
        chk("async_rst_dir", int'(dir_up), 1);
        step();
        rst = 1'b0;
        step();

        // Single call to the top floor.
        req = 4'b1000;
        step();
        req = '0;
        chk("single_pending", int'(pending), 8);
        for (int k = 2; k <= 23; k++) begin
            step();
            chk($sformatf("single_k%0d_moving", k), int'(moving), int'(k >= 2 && k <= 13));
            chk($sformatf("single_k%0d_cf", k), int'(cf),
                (k < 6) ? 0 : (k < 10) ? 1 : (k < 14) ? 2 : 3);
            chk($sformatf("single_k%0d_door", k), int'(door_open), int'(k >= 14 && k <= 21));
        end
        chk("single_end_pending", int'(pending), 0);

        // SCAN order: calls at floor 2 (ahead) and 0 (behind) issued at floor 1.
        do_reset();
        req = 4'b1000;
        step();
        req = '0;
        nstops = 0;
        inj = 1'b0;
        prev_door = 1'b0;
        for (int c = 0; c < 200 && nstops < 3; c++) begin
            step();
            req = '0;
            if (door_open && !prev_door) begin
                stops[nstops] = int'(cf);
                nstops++;
            end
            prev_door = door_open;
            if (cf == 2'd1 && !inj) begin
                req = 4'b0101;
                inj = 1'b1;
            end
        end
        chk("scan_stop_count", nstops, 3);
        if (nstops == 3) begin
            chk("scan_stop0", stops[0], 2);
            chk("scan_stop1", stops[1], 3);
            chk("scan_stop2", stops[2], 0);
        end
        chk("scan_dir_down", int'(dir_up), 0);
        for (int c = 0; c < 20 && door_open; c++) step();
        chk("scan_pending_done", int'(pending), 0);
        chk("scan_door_closed", int'(door_open), 0);

        // Door hold: a call to the open floor on door cycle 6 reloads the timer.
        req = 4'b0100;
        step();
        req = '0;
        for (int c = 0; c < 40 && !door_open; c++) step();
        chk("hold_floor", int'(cf), 2);
        d = 0;
        pend_bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!door_open) break;
            d++;
            if (d == 6) req = 4'b0100;
            step();
            req = '0;
            if (d >= 6 && pending[2]) pend_bad = 1'b1;
        end
        chk("hold_door_cycles", d, 14);
        chk("hold_pending2_clear", int'(pend_bad), 0);

`ifdef ELEV_ESTOP_EN
        // Emergency stop for 10 cycles mid-move delays arrival by 10 cycles.
        do_reset();
        req = 4'b1000;
        step();
        req = '0;
        first_door = -1;
        for (int k = 2; k <= 40; k++) begin
            if (k == 8)  estop = 1'b1;
            if (k == 18) estop = 1'b0;
            step();
            if (k >= 8 && k <= 17) begin
                chk($sformatf("estop_k%0d_cf", k), int'(cf), 1);
                chk($sformatf("estop_k%0d_moving", k), int'(moving), 0);
            end
            if (door_open && first_door < 0) first_door = k;
        end
        chk("estop_arrival", first_door, 24);
        chk("estop_floor", int'(cf), 3);
`else
        first_door = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
